// File: rtl/core_bus_arbiter.sv
// Shares one data-memory port between the IFU (read-only) and the LSU, one transaction at a time.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on ties instead of fixed LSU priority.
module core_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [31:0] ifu_req_addr,
   output logic        ifu_rsp_valid,
   output logic [31:0] ifu_rsp_data,
   output logic        ifu_rsp_err,
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic        lsu_req_wen,
   input  logic [2:0]  lsu_req_rwtyp,
   input  logic [31:0] lsu_req_addr,
   input  logic [31:0] lsu_req_wdata,
   output logic        lsu_rsp_valid,
   output logic [31:0] lsu_rsp_rdata,
   output logic        lsu_rsp_err,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_wen,
   output logic [2:0]  mem_rwtyp,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

   // Fires when the counter's next value would reach TIMEOUT_CYCLES-1.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 2);

   state_e      state_q, state_d;
   logic        owner_q, owner_d;      // 1 = LSU, 0 = IFU; doubles as last grant
   logic [15:0] cnt_q, cnt_d;
   logic        mem_vld_q, mem_vld_d;
   logic        mem_wen_q, mem_wen_d;
   logic [2:0]  mem_rwtyp_q, mem_rwtyp_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        ifu_rsp_q, ifu_rsp_d;
   logic        lsu_rsp_q, lsu_rsp_d;
   logic        ifu_err_q, ifu_err_d;
   logic        lsu_err_q, lsu_err_d;
   logic [31:0] rsp_data_q, rsp_data_d;

   logic can_accept, grant_lsu, grant_ifu, do_rsp, do_to;

   always_comb begin
      can_accept = (state_q == IDLE) && !(ifu_rsp_q || lsu_rsp_q);
`ifdef ARB_ROUND_ROBIN_EN
      grant_lsu  = lsu_req_valid && (!ifu_req_valid || !owner_q);
`else
      grant_lsu  = lsu_req_valid;
`endif
      grant_ifu  = ifu_req_valid && !grant_lsu;
   end

   assign ifu_req_ready = can_accept && grant_ifu;
   assign lsu_req_ready = can_accept && grant_lsu;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      mem_vld_d   = mem_vld_q;
      mem_wen_d   = mem_wen_q;
      mem_rwtyp_d = mem_rwtyp_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ifu_rsp_d   = 1'b0;
      lsu_rsp_d   = 1'b0;
      ifu_err_d   = 1'b0;
      lsu_err_d   = 1'b0;
      rsp_data_d  = rsp_data_q;
      do_rsp      = 1'b0;
      do_to       = 1'b0;
      case (state_q)
         IDLE: begin
            if (lsu_req_ready) begin
               owner_d     = 1'b1;
               mem_wen_d   = lsu_req_wen;
               mem_rwtyp_d = lsu_req_rwtyp;
               mem_addr_d  = lsu_req_addr;
               mem_wdata_d = lsu_req_wdata;
               mem_vld_d   = 1'b1;
               state_d     = REQ;
            end else if (ifu_req_ready) begin
               owner_d     = 1'b0;
               mem_wen_d   = 1'b0;
               mem_rwtyp_d = 3'b010;
               mem_addr_d  = ifu_req_addr;
               mem_wdata_d = 32'h0;
               mem_vld_d   = 1'b1;
               state_d     = REQ;
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               mem_vld_d = 1'b0;
               cnt_d     = 16'h0;
               if (mem_rsp_valid) do_rsp = 1'b1;
               else               state_d = WAIT;
            end
         end
         WAIT: begin
            if (mem_rsp_valid) begin
               do_rsp = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               do_rsp = 1'b1;
               do_to  = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // A real response wins over a timeout landing in the same cycle.
      if (do_rsp) begin
         state_d    = IDLE;
         rsp_data_d = (do_to || mem_wen_q) ? 32'h0 : mem_rdata;
         if (owner_q) begin
            lsu_rsp_d = 1'b1;
            lsu_err_d = do_to;
         end else begin
            ifu_rsp_d = 1'b1;
            ifu_err_d = do_to;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         cnt_q       <= 16'h0;
         mem_vld_q   <= 1'b0;
         mem_wen_q   <= 1'b0;
         mem_rwtyp_q <= 3'b000;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         ifu_rsp_q   <= 1'b0;
         lsu_rsp_q   <= 1'b0;
         ifu_err_q   <= 1'b0;
         lsu_err_q   <= 1'b0;
         rsp_data_q  <= 32'h0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         mem_vld_q   <= mem_vld_d;
         mem_wen_q   <= mem_wen_d;
         mem_rwtyp_q <= mem_rwtyp_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ifu_rsp_q   <= ifu_rsp_d;
         lsu_rsp_q   <= lsu_rsp_d;
         ifu_err_q   <= ifu_err_d;
         lsu_err_q   <= lsu_err_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign mem_req_valid = mem_vld_q;
   assign mem_wen       = mem_wen_q;
   assign mem_rwtyp     = mem_rwtyp_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign ifu_rsp_valid = ifu_rsp_q;
   assign ifu_rsp_data  = rsp_data_q;
   assign ifu_rsp_err   = ifu_err_q;
   assign lsu_rsp_valid = lsu_rsp_q;
   assign lsu_rsp_rdata = rsp_data_q;
   assign lsu_rsp_err   = lsu_err_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter with TIMEOUT_CYCLES=8.
module tb_core_bus_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
   logic [31:0] ifu_req_addr, ifu_rsp_data;
   logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_err;
   logic [2:0]  lsu_req_rwtyp;
   logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
   logic [2:0]  mem_rwtyp;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_chk = 0;
   int n_pass = 0;

   core_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rstn(rstn),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
      .lsu_req_rwtyp(lsu_req_rwtyp), .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
      .mem_rwtyp(mem_rwtyp), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   function automatic logic [31:0] all_out();
      return {ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, lsu_req_ready, lsu_rsp_valid,
              lsu_rsp_err, mem_req_valid, mem_wen, mem_rwtyp} | ifu_rsp_data | lsu_rsp_rdata
             | mem_addr | mem_wdata;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int g, pulses, lsu_pulses, bad;
      logic [3:0] gl, gl_exp;
      rstn = 1'b0;
      ifu_req_valid = 0; ifu_req_addr = 0;
      lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_rwtyp = 0; lsu_req_addr = 0; lsu_req_wdata = 0;
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
      #23;
      chk("reset_outputs", all_out(), 32'h0);
      tick();
      rstn = 1'b1;
      tick();

      // LSU store: mem fields passed through, response data forced to 0
      lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_rwtyp = 3'b000;
      lsu_req_addr = 32'h200; lsu_req_wdata = 32'h12345678;
      #1 chk("st_lsu_ready", lsu_req_ready, 1);
      chk("st_ifu_ready", ifu_req_ready, 0);
      tick();
      lsu_req_valid = 0;
      chk("st_mem_valid", mem_req_valid, 1);
      chk("st_mem_fields", {mem_wen, mem_rwtyp, mem_addr[27:0]}, {1'b1, 3'b000, 28'h200});
      chk("st_mem_wdata", mem_wdata, 32'h12345678);
      mem_req_ready = 1; mem_rsp_valid = 1; mem_rdata = 32'hFFFFFFFF;
      tick();
      mem_req_ready = 0; mem_rsp_valid = 0;
      chk("st_rsp", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid}, 3'b100);
      chk("st_rdata", lsu_rsp_rdata, 32'h0);
      tick();
      chk("st_rsp_end", lsu_rsp_valid, 0);

      // IFU read: memory ready at cycle 1, data at cycle 3, pulse at cycle 4
      ifu_req_valid = 1; ifu_req_addr = 32'h100;
      #1 chk("rd_ifu_ready", {ifu_req_ready, lsu_req_ready}, 2'b10);
      tick();
      ifu_req_valid = 0;
      chk("rd_mem_fields", {mem_req_valid, mem_wen, mem_rwtyp}, {1'b1, 1'b0, 3'b010});
      chk("rd_mem_addr", mem_addr, 32'h100);
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      chk("rd_c2_valid", mem_req_valid, 0);
      tick();
      chk("rd_c3_rsp", ifu_rsp_valid, 0);
      mem_rsp_valid = 1; mem_rdata = 32'hDEADBEEF;
      tick();
      mem_rsp_valid = 0;
      chk("rd_c4_rsp", {ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid}, 3'b100);
      chk("rd_c4_data", ifu_rsp_data, 32'hDEADBEEF);
      tick();
      chk("rd_c5_rsp", ifu_rsp_valid, 0);

      // Both requesters valid for 4 transactions
      g = 0; pulses = 0; lsu_pulses = 0; gl = 0;
      ifu_req_valid = 1; ifu_req_addr = 32'h700;
      lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_rwtyp = 3'b010; lsu_req_addr = 32'h600;
      mem_req_ready = 1; mem_rsp_valid = 1; mem_rdata = 32'h1111;
      #1;
      for (int c = 0; c < 60 && g < 4; c++) begin
         if (ifu_rsp_valid || lsu_rsp_valid) pulses++;
         if (lsu_rsp_valid) lsu_pulses++;
         if (lsu_req_ready || ifu_req_ready) begin
            gl[g] = lsu_req_ready;
            g++;
         end
         tick();
      end
      ifu_req_valid = 0; lsu_req_valid = 0;
      for (int d = 0; d < 4; d++) begin
         if (ifu_rsp_valid || lsu_rsp_valid) pulses++;
         if (lsu_rsp_valid) lsu_pulses++;
         tick();
      end
      mem_req_ready = 0; mem_rsp_valid = 0;
`ifdef ARB_ROUND_ROBIN_EN
      gl_exp = 4'b0101;
`else
      gl_exp = 4'b1111;
`endif
      chk("tie_grant_cnt", g, 4);
      chk("tie_grants", gl, gl_exp);
      chk("tie_pulses", pulses, 4);
      chk("tie_lsu_pulses", lsu_pulses, (gl_exp == 4'b1111) ? 4 : 2);

      // Timeout: accepted by memory at t=cycle1, err pulse at t+8
      ifu_req_valid = 1; ifu_req_addr = 32'h300; mem_rdata = 32'hA5A5A5A5;
      #1 chk("to_ready", ifu_req_ready, 1);
      tick();
      ifu_req_valid = 0; mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      bad = 0;
      for (int k = 2; k <= 8; k++) begin
         if (ifu_rsp_valid || lsu_rsp_valid) bad++;
         tick();
      end
      chk("to_early_pulse", bad, 0);
      chk("to_rsp", {ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid}, 3'b110);
      chk("to_data", ifu_rsp_data, 32'h0);
      tick();
      chk("to_rsp_end", {ifu_rsp_valid, ifu_rsp_err}, 2'b00);
      lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_rwtyp = 3'b010; lsu_req_addr = 32'h400;
      #1 chk("to_next_ready", lsu_req_ready, 1);
      tick();
      lsu_req_valid = 0; mem_req_ready = 1; mem_rsp_valid = 1; mem_rdata = 32'hCAFEF00D;
      tick();
      mem_req_ready = 0; mem_rsp_valid = 0;
      chk("to_next_rsp", {lsu_rsp_valid, lsu_rsp_err}, 2'b10);
      chk("to_next_data", lsu_rsp_rdata, 32'hCAFEF00D);
      tick();

      // mem_req_ready held low past the timeout length: REQ never times out
      lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_rwtyp = 3'b001;
      lsu_req_addr = 32'h500; lsu_req_wdata = 32'h55AA;
      tick();
      lsu_req_valid = 0;
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         if (!mem_req_valid || !mem_wen || mem_rwtyp != 3'b001 || mem_addr != 32'h500
             || mem_wdata != 32'h55AA || lsu_rsp_valid || ifu_rsp_valid) bad++;
         tick();
      end
      chk("stall_stable", bad, 0);
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      chk("stall_wait", {mem_req_valid, lsu_rsp_valid}, 2'b00);
      mem_rsp_valid = 1;
      tick();
      mem_rsp_valid = 0;
      chk("stall_rsp", {lsu_rsp_valid, lsu_rsp_err}, 2'b10);
      tick();

      // Reset during WAIT: outputs clear at once, no stale response later
      ifu_req_valid = 1; ifu_req_addr = 32'h900;
      tick();
      ifu_req_valid = 0; mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      tick();
      #2 rstn = 1'b0;
      #1 chk("rst_wait_outputs", all_out(), 32'h0);
      tick();
      rstn = 1'b1;
      mem_rsp_valid = 1; mem_rdata = 32'h77777777;
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         if (ifu_rsp_valid || lsu_rsp_valid || mem_req_valid) bad++;
         tick();
      end
      mem_rsp_valid = 0;
      chk("rst_no_stale", bad, 0);
      chk("rst_data_zero", ifu_rsp_data, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
